// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control stage: opcode and state encodings,
// plus the bit positions of the fields inside an instruction word.
package alu_pkg;

  typedef enum logic [2:0] {
    INC  = 3'b000,
    DEC  = 3'b001,
    NOT  = 3'b010,
    MASK = 3'b011,
    SHL  = 3'b100,
    SHR  = 3'b101,
    ORLO = 3'b110,
    CLR  = 3'b111
  } opcode_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  localparam int LOAD_BIT = 15;
  localparam int IMM_MSB  = 14;
  localparam int IMM_LSB  = 8;
  localparam int REP_MSB  = 7;
  localparam int REP_LSB  = 4;

endpackage

// File: rtl/alu_ctrl.sv
// Control stage feeding the 16-bit ALU: instruction handshake, accumulator and repeat loop.
// Optional early retirement on a zero result (and a `zero` flag) under ALU_CTRL_ZERO_STOP_EN.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_ACC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      in_instr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      alu_instruction,
  output logic [WIDTH-1:0] alu_operand,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc_out,
  output logic             done,
`ifdef ALU_CTRL_ZERO_STOP_EN
  output logic             zero,
`endif
  output logic [7:0]       instr_count
);

  state_e           state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [15:0]      instr_q, instr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             done_nx;
  logic [7:0]       count_nx;
  logic             accept;
  logic             last_exec;

  assign in_ready        = (state == IDLE);
  assign accept          = in_valid && in_ready;
  assign alu_instruction = instr_q;
  assign alu_operand     = acc;
  assign acc_out         = acc;

  // A zero result may cut the repeat loop short when early stop is built in.
`ifdef ALU_CTRL_ZERO_STOP_EN
  assign last_exec = (cnt == '0) || (alu_result == '0);
`else
  assign last_exec = (cnt == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= RESET_ACC;
      instr_q     <= 16'h0000;
      cnt         <= '0;
      done        <= 1'b0;
      instr_count <= 8'd0;
    end else begin
      state       <= state_nx;
      acc         <= acc_nx;
      instr_q     <= instr_nx;
      cnt         <= cnt_nx;
      done        <= done_nx;
      instr_count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    instr_nx = instr_q;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    count_nx = instr_count;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_instr[LOAD_BIT]) begin
            acc_nx   = WIDTH'(in_instr[IMM_MSB:IMM_LSB]);
            done_nx  = 1'b1;
            count_nx = instr_count + 8'd1;
          end else begin
            instr_nx = in_instr;
            cnt_nx   = in_instr[CNT_W+REP_LSB-1:REP_LSB];
            state_nx = EXEC;
          end
        end
      end
      EXEC: begin
        acc_nx = alu_result;
        if (last_exec) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          count_nx = instr_count + 8'd1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef ALU_CTRL_ZERO_STOP_EN
  // Flag tracks the accumulator, refreshed only when the accumulator is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      zero <= 1'b0;
    else if ((state == EXEC) || (accept && in_instr[LOAD_BIT]))
      zero <= (acc_nx == '0);
  end
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed, table-driven bench for alu_ctrl with a behavioural ALU closing the loop.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_instruction;
  logic [15:0] alu_operand;
  logic [15:0] alu_result;
  logic [15:0] acc_out;
  logic        done;
  logic [7:0]  instr_count;
`ifdef ALU_CTRL_ZERO_STOP_EN
  logic        zero;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .in_instr        (in_instr),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .alu_instruction (alu_instruction),
    .alu_operand     (alu_operand),
    .alu_result      (alu_result),
    .acc_out         (acc_out),
    .done            (done),
`ifdef ALU_CTRL_ZERO_STOP_EN
    .zero            (zero),
`endif
    .instr_count     (instr_count)
  );

  // Reference ALU model
  always_comb begin
    case (alu_instruction[2:0])
      3'd0:    alu_result = alu_operand + 16'd1;
      3'd1:    alu_result = alu_operand - 16'd1;
      3'd2:    alu_result = ~alu_operand;
      3'd3:    alu_result = alu_operand & 16'h00FF;
      3'd4:    alu_result = alu_operand << 1;
      3'd5:    alu_result = alu_operand >> 1;
      3'd6:    alu_result = alu_operand | 16'h00FF;
      default: alu_result = 16'h0000;
    endcase
  end

  typedef struct {
    logic [15:0] instr;
    int          cycles;
    logic [15:0] acc;
    logic [7:0]  count;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_instr = 16'h0000;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    int busy;
    int pulses;
    in_instr = v.instr;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_instr = 16'hBEEF;
    busy     = 0;
    pulses   = done ? 1 : 0;
    while (!in_ready && busy < 40) begin
      busy++;
      tick();
      if (done) pulses++;
    end
    chk($sformatf("v%0d busy cycles", idx), busy, v.cycles);
    chk($sformatf("v%0d done pulses", idx), pulses, 1);
    chk($sformatf("v%0d acc", idx), acc_out, v.acc);
    chk($sformatf("v%0d instr_count", idx), instr_count, v.count);
    if (!v.instr[15]) chk($sformatf("v%0d alu_instruction", idx), alu_instruction, v.instr);
    tick();
    chk($sformatf("v%0d done low after", idx), done, 1'b0);
  endtask

  initial begin
    int pulses;
    bit ready_ok;

    vecs[0]  = '{16'h8500, 0, 16'h0005, 8'd1};
    vecs[1]  = '{16'h0030, 4, 16'h0009, 8'd2};
    vecs[2]  = '{16'hC000, 0, 16'h0040, 8'd3};
    vecs[3]  = '{16'h0094, 10, 16'h0000, 8'd4};
    vecs[4]  = '{16'h8000, 0, 16'h0000, 8'd5};
    vecs[5]  = '{16'h0001, 1, 16'hFFFF, 8'd6};
    vecs[6]  = '{16'h0F02, 1, 16'h0000, 8'd7};
    vecs[7]  = '{16'h8100, 0, 16'h0001, 8'd8};
`ifdef ALU_CTRL_ZERO_STOP_EN
    vecs[8]  = '{16'h0055, 1, 16'h0000, 8'd9};
`else
    vecs[8]  = '{16'h0055, 6, 16'h0000, 8'd9};
`endif
    vecs[9]  = '{16'hFF00, 0, 16'h007F, 8'd10};
    vecs[10] = '{16'h0008, 1, 16'h0080, 8'd11};

    do_reset();
    chk("reset acc", acc_out, 16'h0000);
    chk("reset operand", alu_operand, 16'h0000);
    chk("reset instr", alu_instruction, 16'h0000);
    chk("reset ready", in_ready, 1'b1);
    chk("reset done", done, 1'b0);
    chk("reset count", instr_count, 8'd0);

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i], i);
`ifdef ALU_CTRL_ZERO_STOP_EN
      if (i == 8) chk("zero flag after SHR", zero, 1'b1);
`endif
    end

    // Reset during EXEC; a different word held valid meanwhile must not be consumed
    in_instr = 16'h8300; in_valid = 1'b1; tick();
    in_instr = 16'h00F0; tick();
    chk("mid acc at accept", acc_out, 16'h0003);
    in_instr = 16'h8A00;
    tick();
    tick();
    chk("busy word ignored acc", acc_out, 16'h0005);
    chk("busy ready low", in_ready, 1'b0);
    chk("busy done low", done, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async rst acc", acc_out, 16'h0000);
    chk("async rst ready", in_ready, 1'b1);
    chk("async rst done", done, 1'b0);
    chk("async rst count", instr_count, 8'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post rst done", done, 1'b0);
    chk("post rst acc", acc_out, 16'h0000);

    // Per-cycle view of INC repeat 3
    apply('{16'h8500, 0, 16'h0005, 8'd1}, 100);
    in_instr = 16'h0030; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    chk("inc accept ready", in_ready, 1'b0);
    chk("inc accept acc", acc_out, 16'h0005);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("inc step%0d acc", k), acc_out, 16'(5 + k));
      chk($sformatf("inc step%0d done", k), done, (k == 4));
      chk($sformatf("inc step%0d ready", k), in_ready, (k == 4));
    end
    chk("inc count", instr_count, 8'd2);

    // 256 back-to-back loads
    do_reset();
    pulses   = 0;
    ready_ok = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_instr = 16'h8000 | (16'(i & 8'h7F) << 8);
      tick();
      if (done) pulses++;
      if (!in_ready) ready_ok = 1'b0;
    end
    in_valid = 1'b0;
    chk("burst done pulses", pulses, 256);
    chk("burst ready held", ready_ok, 1'b1);
    chk("burst count wrap", instr_count, 8'd0);
    chk("burst last acc", acc_out, 16'h007F);
    tick();
    chk("burst done low after", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
